mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
Iterative multiply/divide unit with architectural HI/LO registers. It consumes operands and mul/div opcodes from the EXE stage outputs, which are the ALU-side consumer of the ID/EXE stage register. It executes MULT/MULTU/DIV/DIVU over multiple cycles and asserts busy so pipeline control can stall issue. It also serves MTHI/MTLO writes and presents hi/lo continuously for MFHI/MFLO.

Parameters:
WIDTH, 32, operand/HI/LO width; only 32 is supported.
ITER, 32, iterations per mul/div operation; must equal WIDTH.

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-low; clock clk
start  input  1  request from EXE; sampled on posedge
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others ignored
opa  input  32  rs operand (dividend / multiplicand / MTHI-MTLO data)
opb  input  32  rt operand (divisor / multiplier)
flush  input  1  exception/ERET kill of the in-flight operation
busy  output  1  high while operation in flight (state != IDLE)
done  output  1  one-cycle pulse when HI/LO updated by mul/div
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- States: IDLE, RUN, FIX. busy = (state != IDLE), combinational from state.
- Reset (reset==0 at posedge): state=IDLE, hi=0, lo=0, done=0, counter=0, internal regs 0. Reset overrides flush and start, including mid-operation.
- Priority at each posedge: reset > flush > start.
- IDLE, start=1, op in {MULT,MULTU,DIV,DIVU}: latch |opa|,|opb| (signed ops take magnitude; unsigned pass through), latch sign_q=opa[31]^opb[31] and sign_r=opa[31] (signed ops only, else 0). Counter=0, go to RUN.
- IDLE, start=1, DIV/DIVU with opb==0: no RUN; next posedge writes lo=32'hFFFFFFFF, hi=opa; done=1 for one cycle; busy never asserted.
- IDLE, start=1, MTHI: hi<=opa next edge. MTLO: lo<=opa. No busy, no done.
- RUN multiply: 64-bit shift-add, one multiplier bit per edge, LSB first.
- RUN divide: restoring division, one quotient bit per edge, MSB first; partial remainder 33 bits.
- RUN: counter increments each edge; after the 32nd iteration edge, go to FIX.
- FIX (one edge): apply signs. Multiply: product negated in 64 bits if sign_q. Divide: quotient negated if sign_q, remainder negated if sign_r. Write {hi,lo}=product, or lo=quotient, hi=remainder. done<=1 for exactly one cycle. Return to IDLE.
- Latency: start edge at cycle k -> busy high during cycles k+1..k+33 -> hi/lo valid and done=1 in cycle k+34, with busy=0 in that cycle.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
- start while busy: ignored, including MTHI/MTLO. Upstream stalls on busy; no queuing.
- flush in RUN or FIX: state->IDLE, hi/lo unchanged, done stays 0. flush in IDLE: start in same cycle discarded.
- done is 0 in every cycle except the FIX write cycle and the divide-by-zero write cycle.
- hi/lo change only on FIX, divide-by-zero, MTHI/MTLO, or reset.

Test Plan:
- Reset low 2 cycles mid-RUN -> busy=0, done=0, hi=lo=0. Then MTHI opa=0x12345678, MTLO opa=0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0, busy never high.
- MULT opa=0xFFFFFFFF opb=2 -> busy 33 cycles, then done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV opa=0xFFFFFFF9 (-7) opb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU opa=100 opb=7 -> lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU opa=7 opb=0 -> next cycle lo=0xFFFFFFFF, hi=7, done=1, busy stays 0.
- MULT 3*5 with flush asserted at busy cycle 10 -> busy drops next cycle, no done, hi/lo retain prior values. A new MULT issued afterwards completes normally: lo=15, hi=0.
- During busy, start with MTLO 0xDEAD and with DIVU 9/3 -> both ignored. Only the original result is written, with a single done pulse at cycle k+34.

Source files
------------

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit owning the architectural HI/LO pair.
// One multiplier/quotient bit per cycle, then a sign fix-up cycle before HI/LO are written.
module mdu_hilo #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER) + 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q;
  logic             sign_q, sign_r_q, is_div_q;

  logic             signed_op_d;
  logic [WIDTH-1:0] mag_a_d, mag_b_d;
  logic [WIDTH:0]   mul_sum_d;
  logic [WIDTH:0]   div_shift_d;
  logic             div_ge_d;
  logic [WIDTH-1:0] div_sub_d;
  logic [2*WIDTH-1:0] prod_d, prod_fix_d;
  logic [WIDTH-1:0] quot_fix_d, rem_fix_d;

  // Operand magnitudes, one iteration step of each algorithm and the final sign fix-up.
  always_comb begin
    signed_op_d = (op == OP_MULT) || (op == OP_DIV);
    mag_a_d     = (signed_op_d && opa[WIDTH-1]) ? (~opa + WIDTH'(1)) : opa;
    mag_b_d     = (signed_op_d && opb[WIDTH-1]) ? (~opb + WIDTH'(1)) : opb;
    mul_sum_d   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    // Remainder stays below the divisor, so the shifted partial remainder fits in WIDTH+1 bits.
    div_shift_d = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge_d    = div_shift_d >= {1'b0, b_q};
    div_sub_d   = div_shift_d[WIDTH-1:0] - b_q;
    prod_d      = {acc_hi_q, acc_lo_q};
    prod_fix_d  = sign_q ? (~prod_d + (2*WIDTH)'(1)) : prod_d;
    quot_fix_d  = sign_q ? (~acc_lo_q + WIDTH'(1)) : acc_lo_q;
    rem_fix_d   = sign_r_q ? (~acc_hi_q + WIDTH'(1)) : acc_hi_q;
  end

  // Control FSM, iterative datapath and HI/LO architectural state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      sign_q   <= 1'b0;
      sign_r_q <= 1'b0;
      is_div_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              case (op)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                  if (op[1] && (opb == '0)) begin
                    lo_q   <= '1;
                    hi_q   <= opa;
                    done_q <= 1'b1;
                  end else begin
                    a_q      <= mag_a_d;
                    b_q      <= mag_b_d;
                    acc_hi_q <= '0;
                    acc_lo_q <= op[1] ? mag_a_d : mag_b_d;
                    sign_q   <= signed_op_d & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                    sign_r_q <= signed_op_d & opa[WIDTH-1];
                    is_div_q <= op[1];
                    cnt_q    <= '0;
                    state_q  <= RUN;
                  end
                end
                OP_MTHI: hi_q <= opa;
                OP_MTLO: lo_q <= opa;
                default: state_q <= IDLE;
              endcase
            end else begin
              state_q <= IDLE;
            end
          end
          RUN: begin
            if (is_div_q) begin
              acc_hi_q <= div_ge_d ? div_sub_d : div_shift_d[WIDTH-1:0];
              acc_lo_q <= {acc_lo_q[WIDTH-2:0], div_ge_d};
            end else begin
              acc_hi_q <= mul_sum_d[WIDTH:1];
              acc_lo_q <= {mul_sum_d[0], acc_lo_q[WIDTH-1:1]};
            end
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(ITER - 1)) begin
              state_q <= FIX;
            end else begin
              state_q <= RUN;
            end
          end
          FIX: begin
            if (is_div_q) begin
              lo_q <= quot_fix_d;
              hi_q <= rem_fix_d;
            end else begin
              {hi_q, lo_q} <= prod_fix_d;
            end
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: a queue holds expected {hi,lo} per mul/div issued,
// popped and compared when done pulses.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  op;
  logic [31:0] opa, opb;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int d0;
  logic [63:0] sb[$];

  mdu_hilo #(.WIDTH(32), .ITER(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_seen++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, q, r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (o)
      3'b000: return 64'(sa * sbv);
      3'b001: return {32'd0, a} * {32'd0, b};
      3'b010: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      3'b011: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    if (o <= 3'b011) sb.push_back(model(o, a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_busy);
    int cnt = 0;
    bit seen = 1'b0;
    logic [63:0] e;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) cnt++;
      @(negedge clk);
    end
    check($sformatf("%s_done", tag), 64'(seen), 64'd1);
    check($sformatf("%s_busy_cycles", tag), 64'(cnt), 64'(exp_busy));
    check($sformatf("%s_busy_at_done", tag), 64'(busy), 64'd0);
    check($sformatf("%s_sb_nonempty", tag), 64'(sb.size() > 0), 64'd1);
    e = (sb.size() > 0) ? sb.pop_front() : 64'd0;
    check($sformatf("%s_hilo", tag), {hi, lo}, e);
    @(negedge clk);
    check($sformatf("%s_done_pulse", tag), 64'(done), 64'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; flush = 1'b0;
    op = 3'b000; opa = 32'd0; opb = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);

    // reset taken in the middle of a multiply
    issue(3'b100, 32'hAAAA5555, 32'd0);
    check("pre_mthi", 64'(hi), 64'hAAAA5555);
    issue(3'b000, 32'd3, 32'd5);
    repeat (5) @(negedge clk);
    check("midrun_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    reset = 1'b1;
    sb.delete();
    repeat (40) @(negedge clk);
    check("rst_mid_no_done", 64'(done_seen), 64'd0);

    issue(3'b100, 32'h12345678, 32'd0);
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_hi", 64'(hi), 64'h12345678);
    issue(3'b101, 32'h9ABCDEF0, 32'd0);
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mtlo_hilo", {hi, lo}, 64'h12345678_9ABCDEF0);
    check("mt_no_done", 64'(done_seen), 64'd0);

    issue(3'b000, 32'hFFFFFFFF, 32'd2);
    wait_done("mult", 33);
    check("mult_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
    issue(3'b001, 32'hFFFFFFFF, 32'd2);
    wait_done("multu", 33);
    check("multu_const", {hi, lo}, 64'h00000001_FFFFFFFE);
    issue(3'b010, 32'hFFFFFFF9, 32'd2);
    wait_done("div_neg", 33);
    check("div_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    issue(3'b011, 32'd100, 32'd7);
    wait_done("divu", 33);
    check("divu_const", {hi, lo}, 64'h00000002_0000000E);
    issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_ovf", 33);
    check("div_ovf_const", {hi, lo}, 64'h00000000_80000000);
    issue(3'b000, 32'h80000000, 32'h80000000);
    wait_done("mult_minmin", 33);
    issue(3'b010, 32'd1234567, 32'hFFFFFFF0);
    wait_done("div_negb", 33);
    issue(3'b011, 32'd7, 32'd0);
    wait_done("divz", 0);
    check("divz_const", {hi, lo}, 64'h00000007_FFFFFFFF);

    // flush at busy cycle 10 discards the multiply
    d0 = done_seen;
    issue(3'b000, 32'd3, 32'd5);
    sb.delete();
    repeat (9) @(negedge clk);
    check("flush_pre_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_done", 64'(done), 64'd0);
    check("flush_hilo", {hi, lo}, 64'h00000007_FFFFFFFF);
    repeat (40) @(negedge clk);
    check("flush_no_done", 64'(done_seen), 64'(d0));
    check("flush_hilo_late", {hi, lo}, 64'h00000007_FFFFFFFF);
    issue(3'b000, 32'd3, 32'd5);
    wait_done("after_flush", 33);
    check("after_flush_const", {hi, lo}, 64'd15);

    // starts while busy are ignored
    d0 = done_seen;
    issue(3'b011, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    start = 1'b1; op = 3'b101; opa = 32'h0000DEAD; opb = 32'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 3'b011; opa = 32'd9; opb = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign", 28);
    repeat (40) @(negedge clk);
    check("ign_one_done", 64'(done_seen), 64'(d0 + 1));
    check("ign_hilo_final", {hi, lo}, 64'h00000002_0000000E);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
